// File: rtl/cla_pkg.sv
// Shared widths and types for the 8-bit carry-lookahead adder.
package cla_pkg;
  localparam int CLA_W = 8;

  typedef logic [CLA_W-1:0] operand_t;
  typedef logic [CLA_W:0]   sum_t;
endpackage

// File: rtl/cla_4bit_group.sv
// One 4-bit lookahead group: flattened sum-of-products carries plus group generate/propagate.
module cla_4bit_group (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:1] c,
  output logic       gg,
  output logic       gp
);

  // Each carry is a direct two-level expression of p, g and cin; no carry feeds another.
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla_8bit.sv
// 8-bit two-group carry-lookahead adder with a registered 9-bit sum.
// No handshake: a and b are sampled on every rising clk edge and sum is valid one cycle later.
module cla_8bit
  import cla_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  operand_t a,
  input  operand_t b,
  output sum_t     sum
);

  logic [CLA_W-1:0] p;
  logic [CLA_W-1:0] g;
  logic [CLA_W:0]   c;
  logic             gg0;
  logic             gp0;
  logic             gg1;
  logic             gp1;
  sum_t             s;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = 1'b0;

  cla_4bit_group u_group0 (
    .p   (p[3:0]),
    .g   (g[3:0]),
    .cin (c[0]),
    .c   (c[3:1]),
    .gg  (gg0),
    .gp  (gp0)
  );

  // Inter-group carries are lookahead terms; the c[0] products vanish since there is no carry-in.
  assign c[4] = gg0 | (gp0 & c[0]);
  assign c[8] = gg1 | (gp1 & gg0) | (gp1 & gp0 & c[0]);

  cla_4bit_group u_group1 (
    .p   (p[7:4]),
    .g   (g[7:4]),
    .cin (c[4]),
    .c   (c[7:5]),
    .gg  (gg1),
    .gp  (gp1)
  );

  assign s = {c[8], p ^ c[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else begin
      sum <= s;
    end
  end

endmodule

// File: tb/tb_cla_8bit.sv
// Bench for cla_8bit: directed, boundary, async-reset and random operands against an arithmetic model.
module tb_cla_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] sum;

  int n_pass;
  int n_total;

  logic [8:0] exp_q[$];

  cla_8bit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sum (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Carry into bit i is whatever spills out of adding the low i bits of each operand.
  function automatic logic [8:0] model_c(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    int mask;
    r = '0;
    for (int i = 1; i <= 8; i++) begin
      mask = (1 << i) - 1;
      r[i] = ((((int'(x) & mask) + (int'(y) & mask)) >> i) & 1) != 0;
    end
    return r;
  endfunction

  function automatic logic [8:0] model_sum(input logic [7:0] x, input logic [7:0] y);
    int t;
    t = int'(x) + int'(y);
    return t[8:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a = 8'd200;
    b = 8'd100;
    #3;
    n_total++;
    if (sum !== 9'h000) $display("FAIL reset_sum: got %h want 000", sum);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'h000) $display("FAIL reset_hold_sum: got %h want 000", sum);
    else n_pass++;
    n_total++;
    if (dut.p !== (a ^ b) || dut.g !== (a & b) || dut.c !== model_c(a, b))
      $display("FAIL reset_pgc: got p=%b g=%b c=%b want p=%b g=%b c=%b",
               dut.p, dut.g, dut.c, a ^ b, a & b, model_c(a, b));
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'd300) $display("FAIL reset_first_load: got %0d want 300", sum);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [7:0] va[6];
    logic [7:0] vb[6];
    va = '{8'd3, 8'd7, 8'd0, 8'd255, 8'd255, 8'd128};
    vb = '{8'd5, 8'd7, 8'd0, 8'd1,   8'd255, 8'd128};
    for (int i = 0; i < 6; i++) begin
      a = va[i];
      b = vb[i];
      #1;
      n_total++;
      if (dut.p !== (va[i] ^ vb[i]) || dut.g !== (va[i] & vb[i]) || dut.c !== model_c(va[i], vb[i]))
        $display("FAIL directed_pgc[%0d]: got p=%b g=%b c=%b want p=%b g=%b c=%b", i,
                 dut.p, dut.g, dut.c, va[i] ^ vb[i], va[i] & vb[i], model_c(va[i], vb[i]));
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (sum !== model_sum(va[i], vb[i]))
        $display("FAIL directed_sum[%0d]: a=%0d b=%0d got %0d want %0d", i, va[i], vb[i],
                 sum, model_sum(va[i], vb[i]));
      else n_pass++;
    end
  endtask

  task automatic test_boundary();
    a = 8'hFF;
    b = 8'h01;
    #1;
    n_total++;
    if (dut.c !== 9'h1FE) $display("FAIL boundary_carry_chain: got c=%h want 1fe", dut.c);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'h100) $display("FAIL boundary_ff_plus_1: got %h want 100", sum);
    else n_pass++;
    a = 8'hFF;
    b = 8'hFF;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'h1FE) $display("FAIL boundary_ff_plus_ff: got %h want 1fe", sum);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    a = 8'd200;
    b = 8'd100;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'd300) $display("FAIL async_pre: got %0d want 300", sum);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (sum !== 9'h000) $display("FAIL async_immediate_clear: got %0d want 0", sum);
    else n_pass++;
    a = 8'd17;
    b = 8'd42;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'h000) $display("FAIL async_hold_during_rst: got %0d want 0", sum);
    else n_pass++;
    rst = 1'b0;
    #2;
    n_total++;
    if (sum !== 9'h000) $display("FAIL async_not_recovered: got %0d want 0", sum);
    else n_pass++;
    a = 8'd200;
    b = 8'd100;
    @(posedge clk); #1;
    n_total++;
    if (sum !== 9'd300) $display("FAIL async_reload: got %0d want 300", sum);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [8:0] exp;
    int errs;
    errs = 0;
    exp_q.delete();
    for (int i = 0; i < 10000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(model_sum(a, b));
      #1;
      if (i % 16 == 0) begin
        n_total++;
        if (dut.p !== (a ^ b) || dut.g !== (a & b) || dut.c !== model_c(a, b)) begin
          if (errs < 10)
            $display("FAIL random_pgc[%0d]: a=%h b=%h got c=%b want c=%b", i, a, b, dut.c, model_c(a, b));
          errs++;
        end else n_pass++;
      end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      n_total++;
      if (sum !== exp) begin
        if (errs < 10)
          $display("FAIL random_sum[%0d]: got %0d want %0d", i, sum, exp);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    a = 8'd0;
    b = 8'd0;
    test_reset();
    test_directed();
    test_boundary();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
